// File: rtl/mem4x10_rd_ctrl_if.sv
// Bus between the read controller, its 4x10 storage and the downstream consumer.
// The slave modport is the controller's view; the master is the environment driving it.
interface mem4x10_rd_ctrl_if #(
    parameter int DW = 10,
    parameter int AW = 2
);
    logic          WPUSH;
    logic [DW-1:0] RDATAIN;
    logic [AW-1:0] RADDR;
    logic [DW-1:0] DOUT;
    logic          DVALID;
    logic          DREADY;

    modport slave (
        input  WPUSH,
        input  RDATAIN,
        input  DREADY,
        output RADDR,
        output DOUT,
        output DVALID
    );

    modport master (
        output WPUSH,
        output RDATAIN,
        output DREADY,
        input  RADDR,
        input  DOUT,
        input  DVALID
    );
endinterface

// File: rtl/mem4x10_rd_ctrl.sv
// Read side of a 4-entry storage: tracks occupancy and read pointer, and presents
// words through a one-deep registered output stage with a valid/ready handshake.
module mem4x10_rd_ctrl #(
    parameter int DW = 10,
    parameter int AW = 2
) (
    input  logic              RCLK,
    input  logic              RESETN,
    input  logic              FLUSH,
    mem4x10_rd_ctrl_if.slave  bus,
    output logic [AW:0]       COUNT,
    output logic              EMPTY,
    output logic              OVERFLOW
);

    localparam logic [AW:0] FULLCNT = (AW+1)'(1 << AW);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    state_t        statenext;
    logic [DW-1:0] dout;
    logic [DW-1:0] doutnext;
    logic [AW-1:0] raddr;
    logic [AW-1:0] raddrnext;
    logic [AW:0]   count;
    logic [AW:0]   countnext;
    logic          ovf;
    logic          ovfnext;

    logic          full;
    logic          xfer;
    logic          load;
    logic          push;

    // A load frees a slot in the same cycle, so a push at full is still accepted then.
    assign full = (count == FULLCNT);
    assign xfer = (state == HOLD) && bus.DREADY;
    assign load = (count != '0) && ((state == IDLE) || bus.DREADY);
    assign push = bus.WPUSH && (!full || load);

    always_comb begin
        statenext = state;
        doutnext  = dout;
        raddrnext = raddr;
        countnext = count;
        ovfnext   = ovf;

        if (load) begin
            doutnext  = bus.RDATAIN;
            raddrnext = raddr + AW'(1);
            statenext = HOLD;
        end else if (xfer) begin
            statenext = IDLE;
        end

        countnext = count + (AW+1)'(push) - (AW+1)'(load);

        if (bus.WPUSH && !push) begin
            ovfnext = 1'b1;
        end

        if (FLUSH) begin
            statenext = IDLE;
            doutnext  = '0;
            raddrnext = '0;
            countnext = '0;
            ovfnext   = 1'b0;
        end
    end

    always_ff @(posedge RCLK) begin
        if (!RESETN) begin
            state <= IDLE;
            dout  <= '0;
            raddr <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= statenext;
            dout  <= doutnext;
            raddr <= raddrnext;
            count <= countnext;
            ovf   <= ovfnext;
        end
    end

    assign bus.RADDR  = raddr;
    assign bus.DOUT   = dout;
    assign bus.DVALID = (state == HOLD);
    assign COUNT      = count;
    assign EMPTY      = (count == '0);
    assign OVERFLOW   = ovf;

endmodule

// File: tb/tb_mem4x10_rd_ctrl.sv
// Directed bench for mem4x10_rd_ctrl with a storage model, a writer, and a
// scoreboard of words expected at the output handshake.
module tb_mem4x10_rd_ctrl;

    logic       RCLK;
    logic       RESETN;
    logic       FLUSH;
    logic [2:0] COUNT;
    logic       EMPTY;
    logic       OVERFLOW;

    logic [9:0] mem [4];
    logic [1:0] wptr;
    logic [9:0] wdata;
    logic       wacc;
    logic [9:0] sb [$];

    int errors = 0;
    int checks = 0;

    mem4x10_rd_ctrl_if #(.DW(10), .AW(2)) bus ();

    mem4x10_rd_ctrl #(.DW(10), .AW(2)) dut (
        .RCLK     (RCLK),
        .RESETN   (RESETN),
        .FLUSH    (FLUSH),
        .bus      (bus),
        .COUNT    (COUNT),
        .EMPTY    (EMPTY),
        .OVERFLOW (OVERFLOW)
    );

    initial RCLK = 1'b0;
    always #5 RCLK = ~RCLK;

    // Storage write lands at the edge, after the controller has sampled the old word.
    assign bus.RDATAIN = mem[bus.RADDR];

    always @(posedge RCLK) begin
        if (!RESETN || FLUSH) begin
            wptr <= 2'd0;
        end else if (bus.WPUSH && wacc) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 2'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wp, input logic [9:0] d, input logic rdy,
                                 input logic fl, input logic acc);
        bus.WPUSH  = wp;
        wdata      = d;
        bus.DREADY = rdy;
        FLUSH      = fl;
        wacc       = acc;
        @(negedge RCLK);
        if (RESETN && !FLUSH && bus.DVALID && bus.DREADY) begin
            checkOutput("xfer_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) checkOutput("xfer_data", 32'(bus.DOUT), 32'(sb.pop_front()));
        end
        @(posedge RCLK);
        if (!RESETN || fl) sb.delete();
        else if (wp && acc) sb.push_back(d);
        #1;
    endtask

    task automatic pushWord(input logic [9:0] d, input logic rdy);
        applyStimulus(1'b1, d, rdy, 1'b0, 1'b1);
    endtask

    task automatic idleCycle(input logic rdy);
        applyStimulus(1'b0, 10'h000, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESETN     = 1'b0;
        FLUSH      = 1'b0;
        bus.WPUSH  = 1'b0;
        bus.DREADY = 1'b0;
        wdata      = 10'h000;
        wacc       = 1'b0;

        // Reset held while every other control is active.
        applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_raddr",    32'(bus.RADDR),  32'd0);
        checkOutput("rst_count",    32'(COUNT),      32'd0);
        checkOutput("rst_dout",     32'(bus.DOUT),   32'd0);
        checkOutput("rst_dvalid",   32'(bus.DVALID), 32'd0);
        checkOutput("rst_overflow", 32'(OVERFLOW),   32'd0);
        checkOutput("rst_empty",    32'(EMPTY),      32'd1);
        RESETN = 1'b1;

        // Single word and first-word latency.
        pushWord(10'h2A5, 1'b1);
        checkOutput("one_count",  32'(COUNT),      32'd1);
        checkOutput("one_dvalid0", 32'(bus.DVALID), 32'd0);
        idleCycle(1'b1);
        checkOutput("one_dvalid1", 32'(bus.DVALID), 32'd1);
        checkOutput("one_dout",    32'(bus.DOUT),   32'h2A5);
        checkOutput("one_raddr",   32'(bus.RADDR),  32'd1);
        checkOutput("one_empty",   32'(EMPTY),      32'd1);
        idleCycle(1'b1);
        checkOutput("one_dvalid2", 32'(bus.DVALID), 32'd0);
        checkOutput("one_dkeep",   32'(bus.DOUT),   32'h2A5);
        checkOutput("one_raddr2",  32'(bus.RADDR),  32'd1);

        // Flush back to slot 0, then fill with the consumer stalled and drain.
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_raddr", 32'(bus.RADDR), 32'd0);
        for (int i = 1; i <= 4; i++) pushWord(10'(i), 1'b0);
        checkOutput("fill_count",  32'(COUNT),      32'd3);
        checkOutput("fill_dout",   32'(bus.DOUT),   32'h001);
        checkOutput("fill_dvalid", 32'(bus.DVALID), 32'd1);
        checkOutput("fill_raddr",  32'(bus.RADDR),  32'd1);
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b1);
            checkOutput("drain_dout",   32'(bus.DOUT),   32'(i + 2));
            checkOutput("drain_dvalid", 32'(bus.DVALID), 32'd1);
        end
        idleCycle(1'b1);
        checkOutput("drain_done",  32'(bus.DVALID), 32'd0);
        checkOutput("drain_raddr", 32'(bus.RADDR),  32'd0);
        checkOutput("drain_empty", 32'(EMPTY),      32'd1);

        // Full storage, then push into the slot being popped, then a rejected push.
        for (int i = 0; i < 5; i++) pushWord(10'(10'h100 + i), 1'b0);
        checkOutput("full_count", 32'(COUNT),    32'd4);
        checkOutput("full_ovf",   32'(OVERFLOW), 32'd0);
        checkOutput("full_dout",  32'(bus.DOUT), 32'h100);
        pushWord(10'h1A0, 1'b1);
        checkOutput("pp_count", 32'(COUNT),     32'd4);
        checkOutput("pp_ovf",   32'(OVERFLOW),  32'd0);
        checkOutput("pp_dout",  32'(bus.DOUT),  32'h101);
        checkOutput("pp_raddr", 32'(bus.RADDR), 32'd2);
        applyStimulus(1'b1, 10'h1B0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_set",   32'(OVERFLOW), 32'd1);
        checkOutput("ovf_count", 32'(COUNT),    32'd4);
        checkOutput("ovf_dout",  32'(bus.DOUT), 32'h101);
        idleCycle(1'b0);
        checkOutput("ovf_sticky", 32'(OVERFLOW), 32'd1);
        for (int i = 0; i < 4; i++) idleCycle(1'b1);
        checkOutput("pp_newword",  32'(bus.DOUT), 32'h1A0);
        checkOutput("ovf_sticky2", 32'(OVERFLOW), 32'd1);
        checkOutput("pp_count0",   32'(COUNT),    32'd0);
        applyStimulus(1'b1, 10'h155, 1'b1, 1'b1, 1'b1);
        checkOutput("fl_ovf",    32'(OVERFLOW),   32'd0);
        checkOutput("fl_count",  32'(COUNT),      32'd0);
        checkOutput("fl_dvalid", 32'(bus.DVALID), 32'd0);
        checkOutput("fl_raddr2", 32'(bus.RADDR),  32'd0);

        // Continuous stream across two pointer wraps, then reset while holding a word.
        for (int i = 0; i < 10; i++) pushWord(10'(10'h200 + i), 1'b1);
        checkOutput("str_count", 32'(COUNT),      32'd1);
        checkOutput("str_raddr", 32'(bus.RADDR),  32'd1);
        checkOutput("str_dout",  32'(bus.DOUT),   32'h208);
        idleCycle(1'b1);
        checkOutput("str_dvalid", 32'(bus.DVALID), 32'd1);
        checkOutput("str_last",   32'(bus.DOUT),   32'h209);
        RESETN = 1'b0;
        idleCycle(1'b1);
        checkOutput("mrst_dvalid", 32'(bus.DVALID), 32'd0);
        checkOutput("mrst_count",  32'(COUNT),      32'd0);
        checkOutput("mrst_raddr",  32'(bus.RADDR),  32'd0);
        checkOutput("mrst_dout",   32'(bus.DOUT),   32'd0);
        checkOutput("mrst_empty",  32'(EMPTY),      32'd1);
        RESETN = 1'b1;

        // Backpressure toggling every cycle.
        for (int i = 0; i < 4; i++) pushWord(10'(10'h3C1 + i), 1'b0);
        checkOutput("bp_fill", 32'(bus.DOUT), 32'h3C1);
        for (int i = 0; i < 7; i++) begin
            idleCycle((i % 2) == 0);
            if (i < 6) begin
                checkOutput("bp_dout",   32'(bus.DOUT),   32'(10'h3C2 + i / 2));
                checkOutput("bp_dvalid", 32'(bus.DVALID), 32'd1);
            end else begin
                checkOutput("bp_done", 32'(bus.DVALID), 32'd0);
                checkOutput("bp_keep", 32'(bus.DOUT),   32'h3C4);
            end
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem4x10_rd_ctrl.md
MEM4X10_RD_CTRL -- requirements
Module: mem4x10_rd_ctrl

Interface
REQ-001 Parameter DW, default 10, data width; SHALL match the 4x10 storage word width.
REQ-002 Parameter AW, default 2, address width; SHALL give depth 2^AW = 4 entries.
REQ-003 RCLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RESETN  input  1  reset; synchronous and active-low, sampled on the rising edge of RCLK.
REQ-005 FLUSH  input  1  synchronous clear of pointer, count and output stage.
REQ-006 WPUSH  input  1  writer committed one word this cycle, coincident with the storage WE.
REQ-007 RDATAIN  input  DW  combinational read data from storage at RADDR.
REQ-008 RADDR  output  AW  storage read address; the read pointer.
REQ-009 DOUT  output  DW  registered output word.
REQ-010 DVALID  output  1  DOUT holds a valid word.
REQ-011 DREADY  input  1  consumer accepts DOUT this cycle.
REQ-012 COUNT  output  AW+1  words held in storage, not yet loaded into DOUT (0..4).
REQ-013 EMPTY  output  1  COUNT == 0, combinational from COUNT.
REQ-014 OVERFLOW  output  1  sticky error flag.

Function
REQ-015 Output stage SHALL be a two-state machine: IDLE (DVALID=0) and HOLD (DVALID=1).
REQ-016 Transfer SHALL occur when DVALID=1 and DREADY=1; DREADY with DVALID=0 SHALL have no effect.
REQ-017 Load SHALL occur when COUNT>0 and (DVALID=0 or DREADY=1): DOUT<=RDATAIN, DVALID<=1, RADDR<=RADDR+1 mod 4, pop counted.
REQ-018 Transfer with no load SHALL move HOLD->IDLE; DOUT SHALL keep its last value.
REQ-019 Transfer with load SHALL stay in HOLD with the new word; back-to-back throughput SHALL be one word per cycle.
REQ-020 HOLD with DREADY=0 SHALL keep DOUT, DVALID and RADDR stable.
REQ-021 COUNT next SHALL be COUNT + push - pop, where push = WPUSH accepted.
REQ-022 WPUSH SHALL be accepted when COUNT<4, or when COUNT==4 and a pop occurs in the same cycle.
REQ-023 WPUSH at COUNT==4 without a pop SHALL be rejected: COUNT stays 4 and OVERFLOW<=1.
REQ-024 OVERFLOW SHALL clear only on reset or FLUSH.
REQ-025 Simultaneous push and pop SHALL leave COUNT unchanged.
REQ-026 First-word latency: WPUSH at edge N into an empty, IDLE block SHALL give COUNT=1 after N and DVALID=1 with that word after N+1.
REQ-027 RADDR SHALL wrap 3->0 with no gap or stall.
REQ-028 FLUSH=1 SHALL set RADDR=0, COUNT=0, DVALID=0 and OVERFLOW=0, overriding push, load and transfer in the same cycle; the writer pointer SHALL be cleared in the same cycle.
REQ-029 Load captures RDATAIN before the same-edge storage write lands; push into the slot being popped at COUNT==4 SHALL therefore be legal and data-correct.

Reset
REQ-030 RESETN=0 at a rising edge SHALL set RADDR=0, COUNT=0, DOUT=0, DVALID=0 and OVERFLOW=0; EMPTY=1 follows.
REQ-031 Reset SHALL override FLUSH, WPUSH and DREADY.
REQ-032 Reset mid-transfer SHALL discard the held word and all stored words.
REQ-033 Outputs SHALL be undefined-free from the first edge with RESETN=0.

Verification
REQ-034 Single word: push 0x2A5 with DREADY=1 -> DVALID=1 and DOUT=0x2A5 one edge after COUNT=1; DVALID=0 the next cycle; RADDR=1.
REQ-035 Fill then drain: push 0x001..0x004 with DREADY=0 -> COUNT reaches 3 with DOUT=0x001 held; DREADY=1 -> outputs 0x001..0x004 on consecutive cycles; RADDR ends at 0; EMPTY=1.
REQ-036 Overflow: DREADY=0, push 6 words -> first word loads into DOUT, COUNT saturates at 4 after the fifth push; sixth push -> OVERFLOW=1; FLUSH -> OVERFLOW=0, COUNT=0, DVALID=0.
REQ-037 Full with concurrent push and pop: COUNT=4, WPUSH=1, DREADY=1 -> COUNT stays 4, no OVERFLOW, popped word is the old slot data.
REQ-038 Wrap and reset: stream 10 words continuously -> order preserved across two RADDR wraps; assert RESETN=0 while DVALID=1 -> next cycle DVALID=0, COUNT=0, RADDR=0, DOUT=0.
REQ-039 Backpressure: DVALID=1 and DREADY toggled 0/1 each cycle over 4 words -> DOUT changes only after cycles with DREADY=1; no word lost or duplicated.
